// File: rtl/shift_regs_window.sv
// shift_regs_window: three-row convolution window builder feeding the PE array.
// Optional SHIFT_REGS_VALID_EN adds re_valid / re_tap tap-strobe outputs.
module shift_regs_window #(
   parameter int SHIFT_REGS_NUM = 70,
   parameter int PIXELS_IN_ROW  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [3:0]                 k,
   input  logic [3:0]                 s,
   input  logic [3:0]                 west_pad,
   input  logic [3:0]                 slab_num,
   input  logic [3:0]                 east_pad,
   input  logic [15:0]                row1_idx,
   input  logic [15:0]                row2_idx,
   input  logic [15:0]                row3_idx,
   input  logic [15:0]                row_start_idx,
   input  logic [15:0]                row_end_idx,
   input  logic [15:0]                reg_start_idx,
   input  logic [15:0]                reg_end_idx,
   input  logic [PIXELS_IN_ROW*8-1:0] row1_pixels_32,
   input  logic [PIXELS_IN_ROW*8-1:0] row2_pixels_32,
   input  logic [PIXELS_IN_ROW*8-1:0] row3_pixels_32,
   input  logic [15:0]                row1_slab_2,
   input  logic [15:0]                row2_slab_2,
   input  logic [15:0]                row3_slab_2,
   input  logic                       conv_min_pixels_add_end,
   input  logic                       conv_pixels_add_end,
   output logic [PIXELS_IN_ROW*8-1:0] re_row1_pixels,
   output logic [PIXELS_IN_ROW*8-1:0] re_row2_pixels,
   output logic [PIXELS_IN_ROW*8-1:0] re_row3_pixels
`ifdef SHIFT_REGS_VALID_EN
   ,
   output logic                       re_valid,
   output logic [3:0]                 re_tap
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   localparam int RW = PIXELS_IN_ROW * 8;

   logic [7:0]    rq [3][1:SHIFT_REGS_NUM];
   logic [7:0]    rd [3][1:SHIFT_REGS_NUM];
   logic [RW-1:0] pix [3];
   logic [15:0]   slab [3];
   logic          zr [3];
   logic [RW-1:0] ob [3];

   logic [16:0]   wp;
   logic [16:0]   sn;
   logic [16:0]   ep;
   logic [16:0]   rs;
   logic [16:0]   re;
   logic [16:0]   reg_n;
   logic [16:0]   col_n;
   logic [16:0]   n;
   logic [16:0]   iv;
   logic [16:0]   sidx;
   logic [16:0]   pofs;
   logic [15:0]   oidx;

   state_t        state_q;
   state_t        state_d;
   logic [3:0]    tap_q;
   logic [3:0]    tap_d;
   logic          end_q;
   logic          end_d;
   logic [3:0]    km1;

   assign pix[0]  = row1_pixels_32;
   assign pix[1]  = row2_pixels_32;
   assign pix[2]  = row3_pixels_32;
   assign slab[0] = row1_slab_2;
   assign slab[1] = row2_slab_2;
   assign slab[2] = row3_slab_2;
   assign zr[0]   = (row1_idx == 16'd0);
   assign zr[1]   = (row2_idx == 16'd0);
   assign zr[2]   = (row3_idx == 16'd0);

   assign wp = {13'd0, west_pad};
   assign sn = {13'd0, slab_num};
   assign ep = {13'd0, east_pad};
   assign rs = {1'b0, reg_start_idx};
   assign re = {1'b0, reg_end_idx};

   assign reg_n = (reg_end_idx >= reg_start_idx) ?
                  (re - rs + 17'd1) : 17'd0;
   assign col_n = (row_end_idx >= row_start_idx) ?
                  ({1'b0, row_end_idx} - {1'b0, row_start_idx} + 17'd1) :
                  17'd0;

   // Pixel count actually copied from the word: smallest of both ranges and the word size.
   always_comb begin
      n = reg_n;
      if (col_n < n)
         n = col_n;
      if (17'(PIXELS_IN_ROW) < n)
         n = 17'(PIXELS_IN_ROW);
   end

   // Next register contents: west pad, slab, word pixels, east pad, later ones winning.
   always_comb begin
      rd   = rq;
      iv   = '0;
      sidx = '0;
      pofs = '0;
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= SHIFT_REGS_NUM; i++) begin
            iv   = 17'(i);
            sidx = iv - wp - 17'd1;
            pofs = iv - rs;
            if (iv <= wp)
               rd[r][i] = 8'h00;
            if (iv > wp && iv <= wp + sn && sidx < 17'd2)
               rd[r][i] = zr[r] ? 8'h00 :
                          (sidx[0] ? slab[r][15:8] : slab[r][7:0]);
            if (iv >= rs && pofs < n)
               rd[r][i] = zr[r] ? 8'h00 :
                          pix[r][{pofs[4:0], 3'b000} +: 8];
            if (iv > re && iv <= re + ep)
               rd[r][i] = 8'h00;
         end
      end
   end

   // Row register file; reset clears every byte so no stale window survives an abort.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++)
            for (int i = 1; i <= SHIFT_REGS_NUM; i++)
               rq[r][i] <= 8'h00;
      end else begin
         rq <= rd;
      end
   end

   // Strided gather: output pixel j reads register 1 + j*s + tap, zero past the row end.
   always_comb begin
      oidx = '0;
      for (int r = 0; r < 3; r++) begin
         ob[r] = '0;
         for (int j = 0; j < PIXELS_IN_ROW; j++) begin
            oidx = 16'd1 + 16'(j) * {12'd0, s} + {12'd0, tap_q};
            if (oidx <= 16'(SHIFT_REGS_NUM))
               ob[r][j*8 +: 8] = rq[r][oidx[6:0]];
         end
      end
   end

   assign re_row1_pixels = ob[0];
   assign re_row2_pixels = ob[1];
   assign re_row3_pixels = ob[2];

   assign km1 = k - 4'd1;

   // Tap sequencer: start on min_end, walk taps, hold the last one until the window ends.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      end_d   = end_q;
      unique case (state_q)
         IDLE: begin
            if (conv_min_pixels_add_end) begin
               state_d = RUN;
               tap_d   = 4'd0;
               end_d   = conv_pixels_add_end;
            end
         end
         RUN: begin
            end_d = end_q | conv_pixels_add_end;
            if (tap_q < km1) begin
               tap_d = tap_q + 4'd1;
               if (tap_q + 4'd1 == km1)
                  state_d = HOLD;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (end_q || conv_pixels_add_end) begin
               state_d = IDLE;
               tap_d   = 4'd0;
               end_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            tap_d   = 4'd0;
            end_d   = 1'b0;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tap_q   <= 4'd0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         end_q   <= end_d;
      end
   end

`ifdef SHIFT_REGS_VALID_EN
   logic shown_q;
   logic shown_d;

   // A tap is fresh on the cycle after entering RUN or after the tap advances.
   always_comb begin
      shown_d = 1'b0;
      if (state_q == IDLE && conv_min_pixels_add_end)
         shown_d = 1'b1;
      if (state_q == RUN && tap_q < km1)
         shown_d = 1'b1;
   end

   // Fresh-tap flag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         shown_q <= 1'b0;
      else
         shown_q <= shown_d;
   end

   assign re_valid = shown_q && (state_q != IDLE);
   assign re_tap   = tap_q;
`endif

endmodule

// File: tb/tb_shift_regs_window.sv
// tb_shift_regs_window: directed vectors for the window builder.
// Exercises load, strided gather, tap sequencing, row zeroing and reset abort.
module tb_shift_regs_window;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [3:0]   k, s, west_pad, slab_num, east_pad;
   logic [15:0]  row1_idx, row2_idx, row3_idx;
   logic [15:0]  row_start_idx, row_end_idx, reg_start_idx, reg_end_idx;
   logic [255:0] row1_pixels_32, row2_pixels_32, row3_pixels_32;
   logic [15:0]  row1_slab_2, row2_slab_2, row3_slab_2;
   logic         conv_min_pixels_add_end, conv_pixels_add_end;
   logic [255:0] re_row1_pixels, re_row2_pixels, re_row3_pixels;
`ifdef SHIFT_REGS_VALID_EN
   logic         re_valid;
   logic [3:0]   re_tap;
`endif

   shift_regs_window dut (
      .clk                     (clk),
      .reset                   (reset),
      .k                       (k),
      .s                       (s),
      .west_pad                (west_pad),
      .slab_num                (slab_num),
      .east_pad                (east_pad),
      .row1_idx                (row1_idx),
      .row2_idx                (row2_idx),
      .row3_idx                (row3_idx),
      .row_start_idx           (row_start_idx),
      .row_end_idx             (row_end_idx),
      .reg_start_idx           (reg_start_idx),
      .reg_end_idx             (reg_end_idx),
      .row1_pixels_32          (row1_pixels_32),
      .row2_pixels_32          (row2_pixels_32),
      .row3_pixels_32          (row3_pixels_32),
      .row1_slab_2             (row1_slab_2),
      .row2_slab_2             (row2_slab_2),
      .row3_slab_2             (row3_slab_2),
      .conv_min_pixels_add_end (conv_min_pixels_add_end),
      .conv_pixels_add_end     (conv_pixels_add_end),
      .re_row1_pixels          (re_row1_pixels),
      .re_row2_pixels          (re_row2_pixels),
      .re_row3_pixels          (re_row3_pixels)
`ifdef SHIFT_REGS_VALID_EN
      ,
      .re_valid                (re_valid),
      .re_tap                  (re_tap)
`endif
   );

   typedef struct {
      string       nm;
      logic [3:0]  wp, sn, ep;
      logic [15:0] slab, rs, re, cs, ce;
      logic [7:0]  pb;
      logic        mn, pe;
      logic [7:0]  e0, e1, e2, e31;
      logic [3:0]  etap;
      logic        evld;
   } vec_t;

   vec_t tbl [9];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [255:0] mk(input logic [7:0] b);
      logic [255:0] w;
      for (int p = 0; p < 32; p++)
         w[p*8 +: 8] = b + 8'(p);
      return w;
   endfunction

   // Registers hold 0 at 1..2, value idx-2 at 3..68, 0 above.
   function automatic logic [255:0] exp_lin(input int t, input int sv);
      logic [255:0] w;
      int idx;
      for (int j = 0; j < 32; j++) begin
         idx = 1 + j * sv + t;
         w[j*8 +: 8] = (idx >= 3 && idx <= 68) ? 8'(idx - 2) : 8'h00;
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] wp, input logic [3:0] sn,
                         input logic [3:0] ep, input logic [15:0] sl,
                         input logic [15:0] rs, input logic [15:0] re,
                         input logic [15:0] cs, input logic [15:0] ce,
                         input logic [7:0] pb, input logic mn,
                         input logic pe);
      west_pad = wp;
      slab_num = sn;
      east_pad = ep;
      row1_slab_2 = sl;
      row2_slab_2 = sl;
      row3_slab_2 = sl;
      reg_start_idx = rs;
      reg_end_idx = re;
      row_start_idx = cs;
      row_end_idx = ce;
      row1_pixels_32 = mk(pb);
      row2_pixels_32 = mk(pb);
      row3_pixels_32 = mk(pb);
      conv_min_pixels_add_end = mn;
      conv_pixels_add_end = pe;
   endtask

   task automatic idle_in();
      set_in(4'd0, 4'd0, 4'd0, 16'h0, 16'd1, 16'd0, 16'd0, 16'd0,
             8'h00, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [255:0] e;

      tbl[0] = '{"s1e1", 4'd1, 4'd0, 4'd0, 16'h0000, 16'd2, 16'd33,
                 16'd0, 16'd31, 8'h00, 1'b1, 1'b0,
                 8'h00, 8'h00, 8'h01, 8'h1e, 4'd0, 1'b1};
      tbl[1] = '{"s1e2", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd34, 16'd34,
                 16'd32, 16'd63, 8'h20, 1'b0, 1'b1,
                 8'h00, 8'h01, 8'h02, 8'h1f, 4'd1, 1'b1};
      tbl[2] = '{"s1e3", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd1, 16'd0,
                 16'd0, 16'd0, 8'h00, 1'b0, 1'b0,
                 8'h01, 8'h02, 8'h03, 8'h20, 4'd2, 1'b1};
      tbl[3] = '{"s1e4", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd1, 16'd0,
                 16'd0, 16'd0, 8'h00, 1'b0, 1'b0,
                 8'h00, 8'h00, 8'h01, 8'h1e, 4'd0, 1'b0};
      tbl[4] = '{"s2e1", 4'd0, 4'd1, 4'd0, 16'h001f, 16'd2, 16'd33,
                 16'd0, 16'd31, 8'ha0, 1'b0, 1'b0,
                 8'h1f, 8'ha0, 8'ha1, 8'hbe, 4'd0, 1'b0};
      tbl[5] = '{"s2e2", 4'd0, 4'd0, 4'd1, 16'h0000, 16'd34, 16'd33,
                 16'd0, 16'd0, 8'h00, 1'b1, 1'b1,
                 8'h1f, 8'ha0, 8'ha1, 8'hbe, 4'd0, 1'b1};
      tbl[6] = '{"s2e3", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd1, 16'd0,
                 16'd0, 16'd0, 8'h00, 1'b0, 1'b0,
                 8'ha0, 8'ha1, 8'ha2, 8'hbf, 4'd1, 1'b1};
      tbl[7] = '{"s2e4", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd1, 16'd0,
                 16'd0, 16'd0, 8'h00, 1'b0, 1'b0,
                 8'ha1, 8'ha2, 8'ha3, 8'h00, 4'd2, 1'b1};
      tbl[8] = '{"s2e5", 4'd0, 4'd0, 4'd0, 16'h0000, 16'd1, 16'd0,
                 16'd0, 16'd0, 8'h00, 1'b0, 1'b0,
                 8'h1f, 8'ha0, 8'ha1, 8'hbe, 4'd0, 1'b0};

      reset = 1'b0;
      k = 4'd3;
      s = 4'd1;
      row1_idx = 16'd1;
      row2_idx = 16'd1;
      row3_idx = 16'd1;
      idle_in();
      step();
      step();
      chk("rst_row1", re_row1_pixels, '0);
      chk("rst_row2", re_row2_pixels, '0);
      chk("rst_row3", re_row3_pixels, '0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].wp, tbl[i].sn, tbl[i].ep, tbl[i].slab,
                tbl[i].rs, tbl[i].re, tbl[i].cs, tbl[i].ce,
                tbl[i].pb, tbl[i].mn, tbl[i].pe);
         step();
         chk8({tbl[i].nm, "_b0"}, re_row1_pixels[7:0], tbl[i].e0);
         chk8({tbl[i].nm, "_b1"}, re_row1_pixels[15:8], tbl[i].e1);
         chk8({tbl[i].nm, "_b2"}, re_row1_pixels[23:16], tbl[i].e2);
         chk8({tbl[i].nm, "_b31"}, re_row1_pixels[255:248], tbl[i].e31);
         chk8({tbl[i].nm, "_r3b31"}, re_row3_pixels[255:248], tbl[i].e31);
`ifdef SHIFT_REGS_VALID_EN
         chk8({tbl[i].nm, "_vld"}, {7'd0, re_valid}, {7'd0, tbl[i].evld});
         if (tbl[i].evld)
            chk8({tbl[i].nm, "_tap"}, {4'd0, re_tap}, {4'd0, tbl[i].etap});
`endif
      end

      k = 4'd6;
      s = 4'd2;
      set_in(4'd2, 4'd0, 4'd0, 16'h0, 16'd3, 16'd34, 16'd1, 16'd32,
             8'd1, 1'b0, 1'b0);
      step();
      set_in(4'd0, 4'd0, 4'd0, 16'h0, 16'd35, 16'd66, 16'd33, 16'd64,
             8'd33, 1'b1, 1'b0);
      step();
      chk("k6_tap0", re_row1_pixels, exp_lin(0, 2));
      set_in(4'd0, 4'd0, 4'd0, 16'h0, 16'd67, 16'd68, 16'd65, 16'd96,
             8'd65, 1'b0, 1'b1);
      step();
      chk("k6_tap1", re_row1_pixels, exp_lin(1, 2));
      idle_in();
      for (int t = 2; t <= 5; t++) begin
         step();
         chk($sformatf("k6_tap%0d", t), re_row1_pixels, exp_lin(t, 2));
      end
      chk("k6_tap5_r3", re_row3_pixels, exp_lin(5, 2));
      step();
      chk("k6_idle", re_row1_pixels, exp_lin(0, 2));

      k = 4'd3;
      s = 4'd1;
      set_in(4'd0, 4'd0, 4'd0, 16'h0, 16'd1, 16'd0, 16'd0, 16'd0,
             8'h00, 1'b1, 1'b0);
      step();
      chk("hold_tap0", re_row1_pixels, exp_lin(0, 1));
      idle_in();
      for (int c = 0; c < 4; c++)
         step();
      chk("hold_tap2", re_row1_pixels, exp_lin(2, 1));
      conv_pixels_add_end = 1'b1;
      step();
      idle_in();
      step();
      chk("hold_exit", re_row1_pixels, exp_lin(0, 1));

      row2_idx = 16'd0;
      set_in(4'd1, 4'd1, 4'd0, 16'h5555, 16'd3, 16'd34, 16'd1, 16'd32,
             8'd1, 1'b0, 1'b0);
      step();
      idle_in();
      row2_idx = 16'd1;
      for (int j = 0; j < 32; j++)
         e[j*8 +: 8] = (j == 0) ? 8'h00 : (j == 1) ? 8'h55 : 8'(j - 1);
      chk("pad_row2", re_row2_pixels, '0);
      chk("pad_row1", re_row1_pixels, e);
      chk("pad_row3", re_row3_pixels, e);

      conv_min_pixels_add_end = 1'b1;
      step();
      idle_in();
      step();
      chk8("abort_pre", re_row1_pixels[7:0], 8'h55);
      reset = 1'b0;
      #2;
      chk("abort_row1", re_row1_pixels, '0);
      chk("abort_row2", re_row2_pixels, '0);
      chk("abort_row3", re_row3_pixels, '0);
      step();
      reset = 1'b1;
      set_in(4'd0, 4'd0, 4'd0, 16'h0, 16'd1, 16'd32, 16'd1, 16'd32,
             8'h41, 1'b1, 1'b0);
      step();
      chk("restart_tap0", re_row1_pixels, mk(8'h41));
      idle_in();
      step();
      e = mk(8'h42);
      e[255:248] = 8'h00;
      chk("restart_tap1", re_row1_pixels, e);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
